// File: rtl/sfr_bank_v2.sv
// sfr_bank_v2: bank of SFR_COUNT per-bit-configurable special function registers in one address window.
// Latency: writes, hardware updates and read-clears land on the next edge; read data and wr_pulse are valid one cycle after the strobe.
// Backpressure: none; every hit access is accepted in its cycle. Optional key-sequence write lock under macro SFR_WR_LOCK_EN.
module sfr_bank_v2 #(
    parameter int unsigned                         SFR_ADDR_WIDTH   = 32,
    parameter int unsigned                         SFR_WIDTH        = 32,
    parameter int unsigned                         SFR_COUNT        = 4,
    parameter logic [SFR_ADDR_WIDTH-1:0]           SFR_BASE_ADDR    = '0,
    parameter logic [SFR_COUNT*SFR_WIDTH-1:0]      IMPLEMENTED_MASK = '0,
    parameter logic [SFR_COUNT*SFR_WIDTH-1:0]      READABLE_MASK    = '0,
    parameter logic [SFR_COUNT*SFR_WIDTH-1:0]      SW_WR_MASK       = '0,
    parameter logic [SFR_COUNT*SFR_WIDTH-1:0]      W1C_MASK         = '0,
    parameter logic [SFR_COUNT*SFR_WIDTH-1:0]      RC_MASK          = '0,
    parameter logic [SFR_COUNT*SFR_WIDTH-1:0]      HW_UPD_MASK      = '0,
    parameter logic [SFR_COUNT*SFR_WIDTH-1:0]      RESET_VALUE      = '0,
    parameter logic [SFR_COUNT*SFR_WIDTH-1:0]      LOCK_MASK        = '0,
    parameter logic [7:0]                          UNLOCK_KEY1      = 8'h55,
    parameter logic [7:0]                          UNLOCK_KEY2      = 8'hAA
) (
    input  logic                               sfr_clk,
    input  logic                               sys_rst_n,
    input  logic [SFR_ADDR_WIDTH-1:0]          sys_addr,
    input  logic                               sys_wr_en,
    input  logic                               sys_rd_en,
    input  logic [SFR_WIDTH-1:0]               sfr_sw_value,
    input  logic [SFR_COUNT*SFR_WIDTH-1:0]     sfr_hw_update,
    input  logic [SFR_COUNT*SFR_WIDTH-1:0]     sfr_hw_value,
    output logic [SFR_COUNT*SFR_WIDTH-1:0]     sfr_value,
    output logic [SFR_WIDTH-1:0]               sfr_rd_data,
    output logic                               sfr_rd_valid,
    output logic [SFR_COUNT-1:0]               sfr_wr_pulse,
    output logic                               sfr_locked
);

    localparam int unsigned N     = SFR_COUNT * SFR_WIDTH;
    localparam int unsigned IDX_W = (SFR_COUNT > 1) ? $clog2(SFR_COUNT) : 1;
    // Size of the data-register window in bytes; the key register sits right after it.
    localparam logic [SFR_ADDR_WIDTH-1:0] WIN_BYTES = SFR_ADDR_WIDTH'(4 * SFR_COUNT);

    logic [N-1:0]              r_regs;
    logic [N-1:0]              w_regs_nxt;
    logic [SFR_WIDTH-1:0]      r_rd_data;
    logic                      r_rd_valid;
    logic [SFR_COUNT-1:0]      r_wr_pulse;

    logic [SFR_ADDR_WIDTH-1:0] w_offset;
    logic                      w_aligned;
    logic                      w_data_hit;
    logic                      w_key_hit;
    logic [IDX_W-1:0]          w_idx;
    logic                      w_wr_hit;
    logic                      w_rd_data_hit;
    logic                      w_rd_any;
    logic                      w_sw_locked;
    logic [N-1:0]              w_wr_bits;
    logic [N-1:0]              w_rd_bits;
    logic [N-1:0]              w_sw_data;
    logic [N-1:0]              w_sw_nxt;
    logic [N-1:0]              w_wr_allow;
    logic [N-1:0]              w_hw_sel;
    logic [N-1:0]              w_sw_sel;
    logic [N-1:0]              w_rc_sel;
    logic [SFR_WIDTH-1:0]      w_rd_word;
    logic [SFR_COUNT-1:0]      w_pulse_nxt;

    // Address decode: addresses below the base wrap to a huge offset and miss the window.
    assign w_offset      = sys_addr - SFR_BASE_ADDR;
    assign w_aligned     = (sys_addr[1:0] == 2'b00);
    assign w_data_hit    = w_aligned && (w_offset < WIN_BYTES);
    assign w_idx         = w_offset[IDX_W+1:2];
    assign w_wr_hit      = sys_wr_en && w_data_hit;
    assign w_rd_data_hit = sys_rd_en && w_data_hit;
    assign w_rd_any      = sys_rd_en && (w_data_hit || w_key_hit);

`ifdef SFR_WR_LOCK_EN
    typedef enum logic [1:0] {
        ST_LOCKED   = 2'd0,
        ST_KEY1     = 2'd1,
        ST_UNLOCKED = 2'd2
    } lock_state_t;

    lock_state_t r_state;
    lock_state_t w_state_nxt;
    logic        w_key_wr;

    assign w_key_hit   = w_aligned && (w_offset == WIN_BYTES);
    assign w_key_wr    = sys_wr_en && w_key_hit;
    // Only the UNLOCKED state lets protected bits through, so a wrong second key also blocks its own write.
    assign w_sw_locked = (r_state != ST_UNLOCKED);
    assign sfr_locked  = w_sw_locked;

    // Lock state register; reset aborts any partial key sequence.
    always_ff @(posedge sfr_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= ST_LOCKED;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Key sequence: advances only on hit writes; any out-of-sequence write re-locks.
    always_comb begin
        w_state_nxt = r_state;
        if (w_key_wr || w_wr_hit) begin
            case (r_state)
                ST_LOCKED:   w_state_nxt = (w_key_wr && sfr_sw_value[7:0] == UNLOCK_KEY1) ? ST_KEY1 : ST_LOCKED;
                ST_KEY1:     w_state_nxt = (w_key_wr && sfr_sw_value[7:0] == UNLOCK_KEY2) ? ST_UNLOCKED : ST_LOCKED;
                ST_UNLOCKED: w_state_nxt = ST_LOCKED;
                default:     w_state_nxt = ST_LOCKED;
            endcase
        end
    end
`else
    assign w_key_hit   = 1'b0;
    assign w_sw_locked = 1'b0;
    assign sfr_locked  = 1'b0;
`endif

    // Spread the single-register hit into per-bit write/read select vectors.
    always_comb begin
        w_wr_bits = '0;
        w_rd_bits = '0;
        for (int i = 0; i < SFR_COUNT; i++) begin
            if (w_idx == IDX_W'(i)) begin
                w_wr_bits[i*SFR_WIDTH +: SFR_WIDTH] = {SFR_WIDTH{w_wr_hit}};
                w_rd_bits[i*SFR_WIDTH +: SFR_WIDTH] = {SFR_WIDTH{w_rd_data_hit}};
            end
        end
    end

    // Per-bit next value: hardware beats software beats read-clear beats hold.
    assign w_sw_data  = {SFR_COUNT{sfr_sw_value}};
    assign w_sw_nxt   = (r_regs & W1C_MASK & ~w_sw_data) | (w_sw_data & ~W1C_MASK);
    assign w_wr_allow = SW_WR_MASK & ~(w_sw_locked ? LOCK_MASK : '0);
    assign w_hw_sel   = HW_UPD_MASK & sfr_hw_update;
    assign w_sw_sel   = w_wr_bits & w_wr_allow;
    assign w_rc_sel   = w_rd_bits & RC_MASK;
    assign w_regs_nxt = IMPLEMENTED_MASK &
                        ( (w_hw_sel & sfr_hw_value)
                        | (~w_hw_sel & w_sw_sel & w_sw_nxt)
                        | (~w_hw_sel & ~w_sw_sel & ~w_rc_sel & r_regs));

    // Read mux over the pre-update contents, plus the one-hot write pulse.
    always_comb begin
        w_rd_word   = '0;
        w_pulse_nxt = '0;
        for (int i = 0; i < SFR_COUNT; i++) begin
            if (w_idx == IDX_W'(i)) begin
                w_rd_word      = r_regs[i*SFR_WIDTH +: SFR_WIDTH] & READABLE_MASK[i*SFR_WIDTH +: SFR_WIDTH];
                w_pulse_nxt[i] = w_wr_hit;
            end
        end
    end

    // Register storage; the reset image is clipped to implemented bits.
    always_ff @(posedge sfr_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_regs <= RESET_VALUE & IMPLEMENTED_MASK;
        end else begin
            r_regs <= w_regs_nxt;
        end
    end

    // Registered read port and write pulses; data is forced to 0 whenever valid is low.
    always_ff @(posedge sfr_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_wr_pulse <= '0;
        end else begin
            r_rd_data  <= w_rd_data_hit ? w_rd_word : '0;
            r_rd_valid <= w_rd_any;
            r_wr_pulse <= w_pulse_nxt;
        end
    end

    assign sfr_value    = r_regs;
    assign sfr_rd_data  = r_rd_data;
    assign sfr_rd_valid = r_rd_valid;
    assign sfr_wr_pulse = r_wr_pulse;

endmodule
